// File: rtl/serial_add_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : serial_add_ctrl_pkg                                       |
// | Purpose  : State encodings and helpers for the bit-serial adder.     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Ceiling log2 for elaboration-time sizing; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_add_ctrl_fa.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : serial_add_ctrl_fa                                        |
// | Purpose  : Combinational 1-bit full adder.                           |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module serial_add_ctrl_fa (
    input  logic ai,
    input  logic bi,
    input  logic ci,
    output logic so,
    output logic co
);

    assign so = ai ^ bi ^ ci;
    assign co = (ai & bi) | (ci & (ai ^ bi));

endmodule
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : serial_add_ctrl                                           |
// | Purpose  : Sequences a 1-bit full adder LSB-first over WIDTH bits.   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int c_CNT_W = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;
    logic [WIDTH-1:0]   r_acc;
    logic               r_carry;
    logic [c_CNT_W-1:0] r_count;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    logic               w_so;
    logic               w_co;
    logic [WIDTH-1:0]   w_acc_next;

    serial_add_ctrl_fa u_fa (
        .ai (r_op_a[0]),
        .bi (r_op_b[0]),
        .ci (r_carry),
        .so (w_so),
        .co (w_co)
    );

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 is the LSB.
    assign w_acc_next = (r_acc >> 1) | (WIDTH'(w_so) << (WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_acc   <= w_acc_next;
                    r_carry <= w_co;
                    r_op_a  <= r_op_a >> 1;
                    r_op_b  <= r_op_b >> 1;
                    r_count <= r_count + c_CNT_W'(1);
                    if (r_count == c_LAST) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_sum   <= w_acc_next;
                        r_cout  <= w_co;
                    end
                end
                // IDLE, DONE and the unreachable encoding all accept a new start.
                default: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_op_a  <= a;
                        r_op_b  <= b;
                        r_carry <= cin;
                        r_count <= '0;
                        r_acc   <= '0;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
`default_nettype wire
